// File: rtl/err_watchdog.sv
// Reset synchronizer, sticky checker-error aggregation and no-progress watchdog.
// Feeds a registered err back to the clock/reset generator and reports clean completion.
module err_watchdog #(
  parameter int NCHK       = 4,
  parameter int TIMEOUT    = 1000,
  parameter int RST_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCHK-1:0] chk_err,
  input  logic            progress,
  input  logic            halt,
  output logic            rst_sync,
  output logic            err,
  output logic [NCHK:0]   err_src,
  output logic [31:0]     err_cycle,
  output logic            done
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {SYNC, RUN, FAULT, DONE} state_t;

  state_t                state;
  logic [RST_STAGES-1:0] sr;
  logic [WDW-1:0]        wd;
  logic [31:0]           cyc;
  logic                  wd_exp;
  logic [NCHK:0]         src_now;

  // Preset by rst asynchronously, release walks zeros through the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '1;
    else     sr <= {sr[RST_STAGES-2:0], 1'b0};
  end

  assign rst_sync = sr[RST_STAGES-1];

  // Expiry needs TIMEOUT consecutive idle cycles, the last one included.
  assign wd_exp  = (wd == WD_LAST) && !progress;
  assign src_now = {wd_exp, chk_err};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      wd        <= '0;
      cyc       <= '0;
      err       <= 1'b0;
      err_src   <= '0;
      err_cycle <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        SYNC: if (!rst_sync) state <= RUN;
        RUN: begin
          cyc <= (cyc == 32'hFFFF_FFFF) ? cyc : cyc + 32'd1;
          wd  <= progress ? '0 : wd + WDW'(1);
          // Fault has priority over a same-cycle halt.
          if (|src_now) begin
            state     <= FAULT;
            err       <= 1'b1;
            err_src   <= src_now;
            err_cycle <= cyc;
          end else if (halt) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/err_watchdog.md
Name: err_watchdog

Overview:
- Sits directly downstream of the testbench clock/reset generator. Consumes its `clk` and `rst`, and produces the `err` signal the generator samples to stop simulation.
- Synchronizes reset release for the DUT.
- Aggregates the per-checker error flags into a sticky error.
- Runs a no-progress watchdog that flags a hung DUT well before the generator's 100000-cycle cap.

Parameters:
- NCHK, 4, number of independent checker error inputs.
- TIMEOUT, 1000, cycles without `progress` before a watchdog fault (must be >= 2).
- RST_STAGES, 2, synchronizer depth for reset deassertion (must be >= 2).

Ports:
- clk  input  1  clock, from the clock/reset generator.
- rst  input  1  reset, asynchronous, active-high, from the clock/reset generator.
- chk_err  input  NCHK  per-checker error flags, sampled on rising `clk`.
- progress  input  1  DUT heartbeat (e.g. instruction retire); any high cycle restarts the watchdog.
- halt  input  1  DUT reports normal completion.
- rst_sync  output  1  reset to the DUT. Asserts asynchronously; deasserts synchronously.
- err  output  1  registered sticky error, fed back to the generator's `err` input.
- err_src  output  NCHK+1  cause capture. Bits [NCHK-1:0] are checkers; bit NCHK is the watchdog.
- err_cycle  output  32  cycle count at which `err` was first set.
- done  output  1  registered; high once `halt` is accepted with no error.

Behaviour:
- **Reset.**
  - Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
  - While `rst` is high: `rst_sync`=1, `err`=0, `err_src`=0, `err_cycle`=0, `done`=0, FSM=SYNC, watchdog and cycle counters=0.
- **Reset synchronizer.**
  - A RST_STAGES-deep shift register is preset to all-ones by `rst` and shifts in 0 each rising edge.
  - `rst_sync` is the last stage. It falls on the RST_STAGES-th rising edge after `rst` falls.
  - If `rst` reasserts mid-sequence, all stages preset to 1 immediately.
- **FSM states:** SYNC, RUN, FAULT, DONE.
  - SYNC -> RUN on the first edge where `rst_sync` is 0. That edge begins cycle 0 of RUN.
  - RUN -> FAULT when any `chk_err` bit is high, or when the watchdog expires.
  - RUN -> DONE when `halt` is high and no fault condition holds that cycle. If both occur in the same cycle, the fault wins.
  - FAULT and DONE are terminal until `rst`. In both, `chk_err`, `progress` and `halt` are ignored.
  - In SYNC, all inputs are ignored and no counters advance.
- **Cycle counter.**
  - 32-bit; increments every RUN cycle.
  - Saturates at 0xFFFFFFFF with no wrap.
- **Watchdog counter.**
  - Clears to 0 on any RUN cycle with `progress`=1; otherwise increments.
  - Expiry occurs when the counter equals TIMEOUT-1 and `progress`=0 in that cycle.
  - Consequence: exactly TIMEOUT consecutive no-progress RUN cycles cause a fault. `progress`=1 in the final cycle prevents it.
- **Error capture.**
  - Registered: `err` rises on the rising edge that ends the detecting cycle.
  - `err` is stable while `clk` is high, so the generator's sampling sees it cleanly.
  - `err_src` latches every fault source active in the detecting cycle (simultaneous sources all captured). Later errors are not ORed in.
  - `err_cycle` latches the cycle-counter value of the detecting cycle.
  - `err`, `err_src` and `err_cycle` hold until `rst`.
- **Completion.** `done` rises on the edge ending the cycle in which `halt` is accepted, and holds. `err` stays 0 in DONE.
- **Output exclusivity.** `done` and `err` are never both 1.

Test Plan:
- **Reset release.** RST_STAGES=2: `rst` high 201 time units (clock period 100) then low -> `rst_sync` falls on the 2nd rising edge after `rst` falls; `err`=0, `done`=0 throughout. Reassert `rst` between those edges -> `rst_sync` returns to 1 immediately.
- **Single checker fault.** NCHK=4: `chk_err`=4'b0100 for one cycle at RUN cycle 37 -> next edge: `err`=1, `err_src`=5'b00100, `err_cycle`=37. A later `chk_err`=4'b0001 leaves `err_src` unchanged.
- **Watchdog boundary.** TIMEOUT=8: `progress` held 0 from RUN cycle 0 -> `err`=1 after cycle 7, `err_src`=5'b10000, `err_cycle`=7. Repeat with `progress`=1 at cycle 7 -> no fault; the watchdog restarts and the next fault lands at cycle 15.
- **Simultaneous sources.** TIMEOUT=8: `chk_err`=4'b1001 in cycle 7 while the watchdog expires -> `err_src`=5'b11001.
- **Halt vs error.** `halt`=1 with `chk_err`=0 at cycle 20 -> `done`=1 next edge, `err`=0; a subsequent `chk_err`=4'b1111 has no effect. Separate run: `halt`=1 and `chk_err`=4'b0010 in the same cycle -> FAULT, `err`=1, `done`=0.
- **Reset mid-fault.** In FAULT, assert `rst` between clock edges -> `err`, `err_src` and `err_cycle` clear to 0 and `rst_sync`=1 asynchronously, before the next edge.
